// File: rtl/anc_chan_sched_if.sv
// -----------------------------------------------------------------------------
// anc_chan_sched_if
// Handshake/bus bundle between the channel scheduler and the ANC core.
//   core_in_valid   scheduler -> core : sample set valid
//   core_ready      core -> scheduler : core accepts the sample set
//   core_e/x/a/u    scheduler -> core : signed error/reference/desired/step
//   core_out_sample core -> scheduler : signed core result
//   core_out_valid  core -> scheduler : result strobe
// Modports: master = scheduler side, slave = core side.
// -----------------------------------------------------------------------------
interface anc_chan_sched_if;
    logic               core_in_valid;
    logic               core_ready;
    logic signed [15:0] core_e;
    logic signed [15:0] core_x;
    logic signed [15:0] core_a;
    logic signed [15:0] core_u;
    logic signed [15:0] core_out_sample;
    logic               core_out_valid;

    modport master (
        output core_in_valid, core_e, core_x, core_a, core_u,
        input  core_ready, core_out_sample, core_out_valid
    );

    modport slave (
        input  core_in_valid, core_e, core_x, core_a, core_u,
        output core_ready, core_out_sample, core_out_valid
    );
endinterface

// File: rtl/anc_chan_sched.sv
// -----------------------------------------------------------------------------
// anc_chan_sched
// Round-robin scheduler sharing one ANC core among NCH audio channels.
// Each channel has a one-deep holding register; pending sets are granted in
// round-robin order, issued via valid/ready, and the core result is returned
// to the owning channel as a one-hot strobe. Overruns and core timeouts are
// flagged sticky.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   ch_valid[NCH]       per-channel new-sample strobe
//   ch_e/x/a/u          16*NCH packed signed samples, channel i at [16i+15:16i]
//   ovr_clr[NCH]        clears sticky overrun flag per channel
//   core                anc_chan_sched_if.master (core handshake and data)
//   ch_out_sample       registered core result, broadcast
//   ch_out_valid[NCH]   one-hot result strobe to the owning channel
//   ch_overrun[NCH]     sticky overrun flags
//   timeout_err         sticky core-timeout flag (rst only clears it)
//   busy                high while in ISSUE or WAIT
//   cur_ch              channel currently granted
//   ovr_cnt[8*NCH]      only with ANC_SCHED_OVR_CNT_EN: 8-bit saturating
//                       overrun counter per channel
//
// Optional feature macro: ANC_SCHED_OVR_CNT_EN
// -----------------------------------------------------------------------------
module anc_chan_sched #(
    parameter int NCH         = 4,
    parameter int CW          = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       ch_valid,
    input  logic [16*NCH-1:0]    ch_e,
    input  logic [16*NCH-1:0]    ch_x,
    input  logic [16*NCH-1:0]    ch_a,
    input  logic [16*NCH-1:0]    ch_u,
    input  logic [NCH-1:0]       ovr_clr,
    anc_chan_sched_if.master     core,
    output logic [15:0]          ch_out_sample,
    output logic [NCH-1:0]       ch_out_valid,
    output logic [NCH-1:0]       ch_overrun,
    output logic                 timeout_err,
    output logic                 busy,
    output logic [CW-1:0]        cur_ch
`ifdef ANC_SCHED_OVR_CNT_EN
    ,
    output logic [8*NCH-1:0]     ovr_cnt
`endif
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [63:0]     hold_q [NCH];     // {e, x, a, u} per channel
    logic [63:0]     hold_d [NCH];
    logic [NCH-1:0]  pend_q, pend_d;
    logic [NCH-1:0]  ovr_q, ovr_d;
    logic [NCH-1:0]  consume;
    logic [NCH-1:0]  ovr_evt;
    logic [CW-1:0]   last_grant_q, last_grant_d;
    logic [CW-1:0]   cur_ch_q, cur_ch_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic            civ_q, civ_d;
    logic [15:0]     e_q, e_d, x_q, x_d, a_q, a_d, u_q, u_d;
    logic [15:0]     out_sample_q, out_sample_d;
    logic [NCH-1:0]  out_valid_q, out_valid_d;
    logic            tout_q, tout_d;
    logic            busy_q, busy_d;

    logic            grant_found;
    logic            hi_found;
    logic [CW-1:0]   grant_ch;
    logic [CW-1:0]   hi_ch;
    logic [63:0]     grant_data;

    // Per-channel capture, pending and overrun logic.
    // A channel's set is consumed only at the ISSUE accept; a new strobe in
    // that same cycle re-arms pend without being an overrun.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            assign consume[gi] = (state_q == ST_ISSUE) && core.core_ready &&
                                 (cur_ch_q == CW'(gi));
            assign ovr_evt[gi] = ch_valid[gi] && pend_q[gi] && !consume[gi];
            assign pend_d[gi]  = ch_valid[gi] || (pend_q[gi] && !consume[gi]);
            assign ovr_d[gi]   = ovr_evt[gi] || (ovr_q[gi] && !ovr_clr[gi]);
            assign hold_d[gi]  = ch_valid[gi] ? {ch_e[16*gi +: 16], ch_x[16*gi +: 16],
                                                 ch_a[16*gi +: 16], ch_u[16*gi +: 16]}
                                              : hold_q[gi];
        end
    endgenerate

`ifdef ANC_SCHED_OVR_CNT_EN
    logic [7:0] ocnt_q [NCH];
    logic [7:0] ocnt_d [NCH];

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ocnt
            // Clear and a new event together leave a count of one.
            assign ocnt_d[gi] = ovr_evt[gi] ? (ovr_clr[gi] ? 8'd1 :
                                               (ocnt_q[gi] == 8'hFF) ? 8'hFF :
                                               ocnt_q[gi] + 8'd1)
                              : (ovr_clr[gi] ? 8'd0 : ocnt_q[gi]);
            assign ovr_cnt[8*gi +: 8] = ocnt_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (rst) begin
                ocnt_q[i] <= 8'd0;
            end else begin
                ocnt_q[i] <= ocnt_d[i];
            end
        end
    end
`endif

    // Round-robin pick: lowest pending index above last_grant, otherwise the
    // lowest pending index overall (wrap). Descending loop so lowest wins.
    always_comb begin
        grant_found = 1'b0;
        hi_found    = 1'b0;
        grant_ch    = '0;
        hi_ch       = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                grant_found = 1'b1;
                grant_ch    = CW'(i);
            end
            if (pend_q[i] && (CW'(i) > last_grant_q)) begin
                hi_found = 1'b1;
                hi_ch    = CW'(i);
            end
        end
        if (hi_found) begin
            grant_ch = hi_ch;
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant_ch == CW'(i)) begin
                grant_data = hold_q[i];
            end
        end
    end

    // Next-state and registered-output logic for the scheduler FSM.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cur_ch_d     = cur_ch_q;
        cnt_d        = cnt_q;
        e_d          = e_q;
        x_d          = x_q;
        a_d          = a_q;
        u_d          = u_q;
        out_sample_d = out_sample_q;
        out_valid_d  = '0;
        tout_d       = tout_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (grant_found) begin
                    cur_ch_d = grant_ch;
                    e_d      = grant_data[63:48];
                    x_d      = grant_data[47:32];
                    a_d      = grant_data[31:16];
                    u_d      = grant_data[15:0];
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (core.core_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (core.core_out_valid) begin
                    out_sample_d = core.core_out_sample;
                    for (int i = 0; i < NCH; i++) begin
                        out_valid_d[i] = (cur_ch_q == CW'(i));
                    end
                    last_grant_d = cur_ch_q;
                    state_d      = ST_IDLE;
                end else if (cnt_q + TW'(1) == TW'(TIMEOUT_CYC)) begin
                    tout_d       = 1'b1;
                    last_grant_d = cur_ch_q;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        civ_d  = (state_d == ST_ISSUE);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pend_q       <= '0;
            ovr_q        <= '0;
            last_grant_q <= CW'(NCH - 1);
            cur_ch_q     <= '0;
            cnt_q        <= '0;
            civ_q        <= 1'b0;
            e_q          <= '0;
            x_q          <= '0;
            a_q          <= '0;
            u_q          <= '0;
            out_sample_q <= '0;
            out_valid_q  <= '0;
            tout_q       <= 1'b0;
            busy_q       <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            ovr_q        <= ovr_d;
            last_grant_q <= last_grant_d;
            cur_ch_q     <= cur_ch_d;
            cnt_q        <= cnt_d;
            civ_q        <= civ_d;
            e_q          <= e_d;
            x_q          <= x_d;
            a_q          <= a_d;
            u_q          <= u_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= out_valid_d;
            tout_q       <= tout_d;
            busy_q       <= busy_d;
            for (int i = 0; i < NCH; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign core.core_in_valid = civ_q;
    assign core.core_e        = e_q;
    assign core.core_x        = x_q;
    assign core.core_a        = a_q;
    assign core.core_u        = u_q;
    assign ch_out_sample      = out_sample_q;
    assign ch_out_valid       = out_valid_q;
    assign ch_overrun         = ovr_q;
    assign timeout_err        = tout_q;
    assign busy               = busy_q;
    assign cur_ch             = cur_ch_q;

endmodule

// File: tb/tb_anc_chan_sched.sv
// -----------------------------------------------------------------------------
// tb_anc_chan_sched
// Directed scoreboard bench for anc_chan_sched (NCH=4, TIMEOUT_CYC=16).
// Stimulus pushes expected issues/results into queues; a monitor pops and
// compares whenever the DUT issues to the core or strobes a channel result.
// A small core model answers each accepted issue from a response queue.
// -----------------------------------------------------------------------------
module tb_anc_chan_sched;
    localparam int NCH = 4;
    localparam int CW  = 3;
    localparam int TO  = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [NCH-1:0]      ch_valid;
    logic [16*NCH-1:0]   ch_e, ch_x, ch_a, ch_u;
    logic [NCH-1:0]      ovr_clr;
    logic [15:0]         ch_out_sample;
    logic [NCH-1:0]      ch_out_valid;
    logic [NCH-1:0]      ch_overrun;
    logic                timeout_err;
    logic                busy;
    logic [CW-1:0]       cur_ch;
`ifdef ANC_SCHED_OVR_CNT_EN
    logic [8*NCH-1:0]    ovr_cnt;
`endif

    anc_chan_sched_if bus ();

    always #5 clk = ~clk;

    anc_chan_sched #(.NCH(NCH), .CW(CW), .TIMEOUT_CYC(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .ch_valid      (ch_valid),
        .ch_e          (ch_e),
        .ch_x          (ch_x),
        .ch_a          (ch_a),
        .ch_u          (ch_u),
        .ovr_clr       (ovr_clr),
        .core          (bus),
        .ch_out_sample (ch_out_sample),
        .ch_out_valid  (ch_out_valid),
        .ch_overrun    (ch_overrun),
        .timeout_err   (timeout_err),
        .busy          (busy),
        .cur_ch        (cur_ch)
`ifdef ANC_SCHED_OVR_CNT_EN
        ,
        .ovr_cnt       (ovr_cnt)
`endif
    );

    typedef struct {
        logic [CW-1:0] ch;
        logic [63:0]   data;   // {e, x, a, u}
    } iss_t;

    typedef struct {
        logic [NCH-1:0] oh;
        logic [15:0]    s;
    } res_t;

    iss_t        iss_q [$];
    res_t        res_q [$];
    logic [16:0] resp_q [$];   // bit16 = core answers, [15:0] = result
    int          resp_dly = 1;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int ch, input logic [15:0] e, input logic [15:0] x,
                        input logic [15:0] a, input logic [15:0] u);
        ch_valid[ch]        = 1'b1;
        ch_e[16*ch +: 16]   = e;
        ch_x[16*ch +: 16]   = x;
        ch_a[16*ch +: 16]   = a;
        ch_u[16*ch +: 16]   = u;
    endtask

    task automatic expect_txn(input int ch, input logic [15:0] e, input logic [15:0] x,
                              input logic [15:0] a, input logic [15:0] u,
                              input logic answer, input logic [15:0] r);
        iss_t it;
        res_t rt;
        it.ch   = CW'(ch);
        it.data = {e, x, a, u};
        iss_q.push_back(it);
        resp_q.push_back({answer, r});
        if (answer) begin
            rt.oh = NCH'(1) << ch;
            rt.s  = r;
            res_q.push_back(rt);
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        ch_valid     = '0;
        ovr_clr      = '0;
        bus.core_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (n < budget && !(iss_q.size() == 0 && res_q.size() == 0 && !busy)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_idle: got timeout after %0d cycles, required idle with %0d issues %0d results left",
                     n, iss_q.size(), res_q.size());
        end
    endtask

    // Core model: answer each accepted issue after resp_dly cycles.
    initial begin
        logic [16:0] r;
        bus.core_out_valid  = 1'b0;
        bus.core_out_sample = '0;
        forever begin
            @(negedge clk);
            if (!rst && bus.core_in_valid && bus.core_ready) begin
                r = (resp_q.size() > 0) ? resp_q.pop_front() : 17'd0;
                tick();
                repeat (resp_dly - 1) tick();
                if (r[16]) begin
                    bus.core_out_valid  = 1'b1;
                    bus.core_out_sample = r[15:0];
                    tick();
                    bus.core_out_valid  = 1'b0;
                end
            end
        end
    end

    // Monitor: compare every issue and every channel result against the queues.
    initial begin
        iss_t it;
        res_t rt;
        forever begin
            @(negedge clk);
            if (!rst && bus.core_in_valid && bus.core_ready) begin
                if (iss_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue: got issue on ch %0d, required none", cur_ch);
                end else begin
                    it = iss_q.pop_front();
                    $display("issue ch=%0d e=%h x=%h a=%h u=%h", cur_ch,
                             bus.core_e, bus.core_x, bus.core_a, bus.core_u);
                    chk("issue_ch", 64'(cur_ch), 64'(it.ch));
                    chk("issue_data", {bus.core_e, bus.core_x, bus.core_a, bus.core_u}, it.data);
                end
            end
            if (ch_out_valid != '0) begin
                if (res_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got ch_out_valid=%b, required none", ch_out_valid);
                end else begin
                    rt = res_q.pop_front();
                    $display("result valid=%b sample=%h", ch_out_valid, ch_out_sample);
                    chk("result_onehot", 64'(ch_out_valid), 64'(rt.oh));
                    chk("result_sample", 64'(ch_out_sample), 64'(rt.s));
                end
            end
        end
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish within 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        ch_e = '0;
        ch_x = '0;
        ch_a = '0;
        ch_u = '0;

        // ---- reset state ----
        do_reset();
        @(negedge clk);
        chk("rst_outputs", {ch_out_valid, ch_overrun, 2'(timeout_err), 2'(busy), 4'(cur_ch)}, 64'd0);
        chk("rst_core", {bus.core_e, bus.core_x, bus.core_a, bus.core_u}, 64'd0);
        chk("rst_civ_sample", {15'd0, bus.core_in_valid, ch_out_sample}, 64'd0);

        // ---- single channel, latency ----
        resp_dly = 3;
        expect_txn(2, 16'h0100, 16'h0200, 16'h0300, 16'h0010, 1'b1, 16'h1234);
        tick();
        load(2, 16'h0100, 16'h0200, 16'h0300, 16'h0010);   // cycle 0
        tick();
        ch_valid = '0;                                      // cycle 1
        @(negedge clk);
        chk("lat_civ_c1", 64'(bus.core_in_valid), 64'd0);
        @(negedge clk);                                     // cycle 2
        chk("lat_civ_c2", 64'(bus.core_in_valid), 64'd1);
        chk("lat_cur_ch", 64'(cur_ch), 64'd2);
        repeat (3) @(negedge clk);                          // cycle 5
        chk("lat_core_ov", {63'd0, bus.core_out_valid}, 64'd1);
        chk("lat_chov_pre", 64'(ch_out_valid), 64'd0);
        @(negedge clk);                                     // cycle 6
        chk("lat_chov", 64'(ch_out_valid), 64'b0100);
        chk("lat_idle", 64'(busy), 64'd0);
        wait_idle(200);

        // ---- round robin ----
        do_reset();
        resp_dly = 1;
        for (int i = 0; i < NCH; i++) begin
            expect_txn(i, 16'h1000 + 16'(i), 16'h2000 + 16'(i), 16'h3000 + 16'(i),
                       16'h4000 + 16'(i), 1'b1, 16'hA000 + 16'(i));
        end
        for (int i = 0; i < NCH; i++) begin
            load(i, 16'h1000 + 16'(i), 16'h2000 + 16'(i), 16'h3000 + 16'(i), 16'h4000 + 16'(i));
        end
        tick();
        ch_valid = '0;
        wait_idle(400);
        chk("rr_no_ovr", 64'(ch_overrun), 64'd0);
        expect_txn(0, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 1'b1, 16'hA100);
        expect_txn(3, 16'h3A3A, 16'h3B3B, 16'h3C3C, 16'h3D3D, 1'b1, 16'hA103);
        tick();
        load(3, 16'h3A3A, 16'h3B3B, 16'h3C3C, 16'h3D3D);
        load(0, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);
        tick();
        ch_valid = '0;
        wait_idle(400);
        chk("rr2_no_ovr", 64'(ch_overrun), 64'd0);

        // ---- backpressure ----
        do_reset();
        resp_dly = 2;
        bus.core_ready = 1'b0;
        expect_txn(1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b1, 16'h5555);
        load(1, 16'h1111, 16'h2222, 16'h3333, 16'h4444);    // cycle 0
        tick();
        ch_valid = '0;                                      // cycle 1
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin                   // cycles 2..6
            @(negedge clk);
            chk("bp_civ_held", 64'(bus.core_in_valid), 64'd1);
            chk("bp_data_held", {bus.core_e, bus.core_x, bus.core_a, bus.core_u},
                64'h1111_2222_3333_4444);
        end
        tick();
        bus.core_ready = 1'b1;                              // cycle 7: accept
        @(negedge clk);
        chk("bp_civ_accept", 64'(bus.core_in_valid), 64'd1);
        @(negedge clk);
        chk("bp_civ_after", 64'(bus.core_in_valid), 64'd0);
        wait_idle(200);

        // ---- overrun ----
        do_reset();
        resp_dly = 6;
        expect_txn(0, 16'h0E00, 16'h0AAA, 16'h0A00, 16'h0001, 1'b1, 16'hB000);
        expect_txn(1, 16'h0E01, 16'h0002, 16'h0A01, 16'h0002, 1'b1, 16'hB001);
        load(0, 16'h0E00, 16'h0AAA, 16'h0A00, 16'h0001);    // cycle 0
        tick();
        ch_valid = '0;                                      // cycle 1
        @(negedge clk);
        @(negedge clk);                                     // cycle 2 accept
        tick();
        load(1, 16'h0E01, 16'h0001, 16'h0A01, 16'h0002);    // cycle 3 (WAIT)
        tick();
        load(1, 16'h0E01, 16'h0002, 16'h0A01, 16'h0002);    // cycle 4 overrun
        tick();
        ch_valid = '0;
        @(negedge clk);
        chk("ovr_flag", 64'(ch_overrun), 64'b0010);
`ifdef ANC_SCHED_OVR_CNT_EN
        chk("ovr_cnt1", 64'(ovr_cnt[15:8]), 64'd1);
`endif
        wait_idle(200);
        chk("ovr_sticky", 64'(ch_overrun), 64'b0010);
        tick();
        ovr_clr[1] = 1'b1;
        tick();
        ovr_clr = '0;
        @(negedge clk);
        chk("ovr_cleared", 64'(ch_overrun), 64'd0);
`ifdef ANC_SCHED_OVR_CNT_EN
        chk("ovr_cnt_clr", 64'(ovr_cnt[15:8]), 64'd0);
`endif

        // ---- timeout ----
        do_reset();
        resp_dly = 1;
        expect_txn(0, 16'h7000, 16'h7001, 16'h7002, 16'h7003, 1'b0, 16'h0000);
        expect_txn(1, 16'h7100, 16'h7101, 16'h7102, 16'h7103, 1'b1, 16'hC001);
        load(0, 16'h7000, 16'h7001, 16'h7002, 16'h7003);
        load(1, 16'h7100, 16'h7101, 16'h7102, 16'h7103);    // cycle 0
        tick();
        ch_valid = '0;                                      // cycle 1
        @(negedge clk);
        @(negedge clk);                                     // cycle 2 = k accept
        repeat (TO) @(negedge clk);                         // k+16
        chk("to_not_yet", {62'd0, timeout_err, busy}, 64'b01);
        @(negedge clk);                                     // k+17
        chk("to_set_idle", {62'd0, timeout_err, busy}, 64'b10);
        chk("to_no_chov", 64'(ch_out_valid), 64'd0);
        @(negedge clk);                                     // k+18
        chk("to_next_issue", {60'd0, bus.core_in_valid, cur_ch}, {60'd0, 1'b1, 3'd1});
        wait_idle(200);
        chk("to_sticky", 64'(timeout_err), 64'd1);

        // ---- reset mid-WAIT ----
        do_reset();
        @(negedge clk);
        chk("rst_clears_to", 64'(timeout_err), 64'd0);
        resp_dly = 4;
        expect_txn(2, 16'h2200, 16'h2201, 16'h2202, 16'h2203, 1'b0, 16'h0000);
        resp_q.pop_back();
        resp_q.push_back({1'b1, 16'hDEAD});                 // late answer, must be ignored
        tick();
        load(2, 16'h2200, 16'h2201, 16'h2202, 16'h2203);    // cycle 0
        tick();
        ch_valid = '0;                                      // cycle 1
        @(negedge clk);
        @(negedge clk);                                     // cycle 2 accept
        tick();
        load(3, 16'h3300, 16'h3301, 16'h3302, 16'h3303);    // cycle 3 (WAIT)
        tick();
        ch_valid = '0;
        rst = 1'b1;                                         // cycle 4 (WAIT)
        tick();
        rst = 1'b0;                                         // cycle 5
        @(negedge clk);
        chk("rmw_outputs", {ch_out_valid, ch_overrun, 2'(timeout_err), 2'(busy), 4'(cur_ch)}, 64'd0);
        chk("rmw_core", {bus.core_e, bus.core_x, bus.core_a, bus.core_u}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rmw_quiet", {ch_out_valid, 1'b0, bus.core_in_valid, busy}, 64'd0);
        end

        checks++;
        if (iss_q.size() != 0 || res_q.size() != 0) begin
            errors++;
            $display("FAIL queues_empty: got %0d issues %0d results left, required 0 0",
                     iss_q.size(), res_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
